branch_cond_unit: RTL and testbench

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_pkg.sv | 35 +++
 rtl/branch_cond_unit_cond_eval.sv | 40 ++++
 rtl/branch_cond_unit.sv | 96 +++++++++
 tb/tb_branch_cond_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch condition unit: branch kinds,
// condition-code encodings and NZCV bit positions.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE  = 3'd0,
    BR_B     = 3'd1,
    BR_BCOND = 3'd2,
    BR_CBZ   = 3'd3,
    BR_CBNZ  = 3'd4
  } br_kind_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Condition-code evaluator: decides whether a 4-bit condition passes
// for a given NZCV flag set. Purely combinational.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    // NOTE: default assigned first so every path drives pass and no latch is inferred.
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1; // AL and NV
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the architectural NZCV register and produces a
// registered taken/not-taken decision for the ID-stage branch, with EX->ID bypass.
module branch_cond_unit
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_set_flags,
  input  logic [3:0]  ex_nzcv,
  input  logic        id_valid,
  input  logic [2:0]  id_kind,
  input  logic [3:0]  id_cond,
  input  logic [63:0] id_operand,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  flags_q,
  output logic        br_valid,
  output logic        br_taken
);

  logic [3:0]  flags_d;
  logic        br_valid_d, br_valid_q;
  logic        br_taken_d, br_taken_q;
  logic        flag_wr;
  logic [3:0]  eff_flags;
  logic        cond_pass;
  logic        is_branch;
  logic        decision;

  // Zero test as a reduction tree: NOR4 per nibble, then two AND4 levels.
  logic [15:0] leaf_nor;
  logic [3:0]  mid_and;
  logic        z64;

  for (genvar g = 0; g < 16; g++) begin : g_leaf
    assign leaf_nor[g] = ~|id_operand[4*g +: 4];
  end

  for (genvar g = 0; g < 4; g++) begin : g_mid
    assign mid_and[g] = &leaf_nor[4*g +: 4];
  end

  assign z64 = &mid_and;

  // An older flag-setting instruction in EX overrides the stored flags.
  assign flag_wr   = ex_valid & ex_set_flags;
  assign eff_flags = flag_wr ? ex_nzcv : flags_q;

  cond_eval u_cond_eval (
    .nzcv (eff_flags),
    .cond (id_cond),
    .pass (cond_pass)
  );

  always_comb begin
    is_branch = 1'b1;
    decision  = 1'b0;
    case (id_kind)
      BR_B:     decision = 1'b1;
      BR_BCOND: decision = cond_pass;
      BR_CBZ:   decision = z64;
      BR_CBNZ:  decision = !z64;
      default:  is_branch = 1'b0;
    endcase
  end

  always_comb begin
    flags_d    = flags_q;
    br_valid_d = br_valid_q;
    br_taken_d = br_taken_q;
    if (!stall) begin
      if (flag_wr) flags_d = ex_nzcv;
      br_valid_d = id_valid & !flush & is_branch;
      br_taken_d = br_valid_d & decision;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and sampled before stall, so it discards held state.
    if (reset) begin
      flags_q    <= 4'b0000;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      flags_q    <= flags_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_valid = br_valid_q;
  assign br_taken = br_taken_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed vector table, hand-written
// stall/flush/reset sequences, a full cond x flags sweep and randomized traffic.
module tb_branch_cond_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_set_flags;
  logic [3:0]  ex_nzcv;
  logic        id_valid;
  logic [2:0]  id_kind;
  logic [3:0]  id_cond;
  logic [63:0] id_operand;
  logic        stall;
  logic        flush;
  logic [3:0]  flags_q;
  logic        br_valid;
  logic        br_taken;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, advanced once per clock edge.
  logic [3:0] m_flags;
  logic       m_valid;
  logic       m_taken;

  branch_cond_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_set_flags (ex_set_flags),
    .ex_nzcv      (ex_nzcv),
    .id_valid     (id_valid),
    .id_kind      (id_kind),
    .id_cond      (id_cond),
    .id_operand   (id_operand),
    .stall        (stall),
    .flush        (flush),
    .flags_q      (flags_q),
    .br_valid     (br_valid),
    .br_taken     (br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ex_wr;
    logic [3:0]  nzcv;
    logic [2:0]  kind;
    logic [3:0]  cond;
    logic [63:0] operand;
    logic        exp_valid;
    logic        exp_taken;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Architectural condition semantics: a base test chosen by cond[3:1],
  // inverted by cond[0] except for the always-true code 15.
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cond);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (cond[0] && cond != 4'd15) r = !r;
    return r;
  endfunction

  function automatic logic decide_ref(input logic [2:0] kind, input logic [3:0] cond,
                                      input logic [63:0] opnd, input logic [3:0] f);
    case (kind)
      3'd1:    return 1'b1;
      3'd2:    return cond_ref(f, cond);
      3'd3:    return opnd == 64'd0;
      3'd4:    return opnd != 64'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    logic [3:0] eff;
    logic       nv, nt;
    eff = (ex_valid && ex_set_flags) ? ex_nzcv : m_flags;
    nv  = id_valid && !flush && (id_kind >= 3'd1) && (id_kind <= 3'd4);
    nt  = nv && decide_ref(id_kind, id_cond, id_operand, eff);
    @(posedge clk);
    if (reset) begin
      m_flags = 4'b0000;
      m_valid = 1'b0;
      m_taken = 1'b0;
    end else if (!stall) begin
      if (ex_valid && ex_set_flags) m_flags = ex_nzcv;
      m_valid = nv;
      m_taken = nt;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; ex_valid = 0; ex_set_flags = 0; ex_nzcv = 4'h0;
    id_valid = 0; id_kind = 3'd0; id_cond = 4'h0; id_operand = 64'h0;
    stall = 0; flush = 0;
  endtask

  task automatic check_state(input string tag, input logic v, input logic t, input logic [3:0] f);
    check({tag, "_valid"}, br_valid, v);
    check({tag, "_taken"}, br_taken, t);
    check({tag, "_flags"}, flags_q, f);
  endtask

  function automatic vec_t mk(input string name, input logic ex_wr, input logic [3:0] nzcv,
                              input logic [2:0] kind, input logic [3:0] cond, input logic [63:0] opnd,
                              input logic ev, input logic et, input logic [3:0] ef);
    vec_t x;
    x.name = name; x.ex_wr = ex_wr; x.nzcv = nzcv; x.kind = kind; x.cond = cond;
    x.operand = opnd; x.exp_valid = ev; x.exp_taken = et; x.exp_flags = ef;
    return x;
  endfunction

  initial begin
    vecs.push_back(mk("ge_1001",      1, 4'b1001, 3'd2, 4'd10, 64'h0, 1, 1, 4'b1001));
    vecs.push_back(mk("gt_1001",      1, 4'b1001, 3'd2, 4'd12, 64'h0, 1, 1, 4'b1001));
    vecs.push_back(mk("lt_1001",      1, 4'b1001, 3'd2, 4'd11, 64'h0, 1, 0, 4'b1001));
    vecs.push_back(mk("eq_bypass",    1, 4'b0100, 3'd2, 4'd0,  64'h0, 1, 1, 4'b0100));
    vecs.push_back(mk("ne_stored",    0, 4'b0000, 3'd2, 4'd1,  64'h0, 1, 0, 4'b0100));
    vecs.push_back(mk("cbz_zero",     0, 4'b0000, 3'd3, 4'd0,  64'h0, 1, 1, 4'b0100));
    vecs.push_back(mk("cbz_msb",      0, 4'b0000, 3'd3, 4'd0,  64'h8000_0000_0000_0000, 1, 0, 4'b0100));
    vecs.push_back(mk("cbnz_one",     0, 4'b0000, 3'd4, 4'd0,  64'h1, 1, 1, 4'b0100));
    vecs.push_back(mk("cbnz_zero",    0, 4'b0000, 3'd4, 4'd0,  64'h0, 1, 0, 4'b0100));
    vecs.push_back(mk("b_uncond",     0, 4'b0000, 3'd1, 4'd0,  64'h0, 1, 1, 4'b0100));
    vecs.push_back(mk("kind_none",    0, 4'b0000, 3'd0, 4'd14, 64'h0, 0, 0, 4'b0100));
    vecs.push_back(mk("kind_7",       0, 4'b0000, 3'd7, 4'd14, 64'h0, 0, 0, 4'b0100));
    vecs.push_back(mk("hi_0010",      1, 4'b0010, 3'd2, 4'd8,  64'h0, 1, 1, 4'b0010));
    vecs.push_back(mk("hi_0110",      1, 4'b0110, 3'd2, 4'd8,  64'h0, 1, 0, 4'b0110));
    vecs.push_back(mk("ls_0110",      0, 4'b0000, 3'd2, 4'd9,  64'h0, 1, 1, 4'b0110));
    vecs.push_back(mk("nv_0000",      1, 4'b0000, 3'd2, 4'd15, 64'h0, 1, 1, 4'b0000));

    idle_inputs();
    m_flags = 4'b0000; m_valid = 1'b0; m_taken = 1'b0;
    reset = 1;
    tick();
    check_state("reset", 1'b0, 1'b0, 4'b0000);
    reset = 0;

    // First decision after reset uses the reset flags: EQ with Z=0 fails.
    id_valid = 1; id_kind = 3'd2; id_cond = 4'd0;
    tick();
    check_state("post_reset_eq", 1'b1, 1'b0, 4'b0000);

    // Invalid EX data must not bypass or load.
    ex_valid = 0; ex_set_flags = 1; ex_nzcv = 4'b0100;
    tick();
    check_state("ex_invalid", 1'b1, 1'b0, 4'b0000);
    idle_inputs();

    foreach (vecs[i]) begin
      ex_valid = vecs[i].ex_wr; ex_set_flags = vecs[i].ex_wr; ex_nzcv = vecs[i].nzcv;
      id_valid = 1; id_kind = vecs[i].kind; id_cond = vecs[i].cond; id_operand = vecs[i].operand;
      tick();
      check_state(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_taken, vecs[i].exp_flags);
    end

    // id_valid low: no decision even for B.
    idle_inputs(); id_kind = 3'd1;
    tick();
    check_state("id_invalid", 1'b0, 1'b0, 4'b0000);

    // Decision, then a three-cycle stall with changing inputs.
    ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'b1000;
    id_valid = 1; id_kind = 3'd2; id_cond = 4'd4;
    tick();
    check_state("mi_taken", 1'b1, 1'b1, 4'b1000);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      ex_nzcv = 4'(k + 3); id_kind = 3'(k); id_cond = 4'(k + 1); id_operand = 64'(k);
      tick();
      check_state($sformatf("stall_%0d", k), 1'b1, 1'b1, 4'b1000);
    end
    flush = 1; id_kind = 3'd1;
    tick();
    check_state("stall_flush", 1'b1, 1'b1, 4'b1000);
    stall = 0; ex_nzcv = 4'b1010;
    tick();
    check_state("flush", 1'b0, 1'b0, 4'b1010);

    // Reset during stall discards everything.
    idle_inputs();
    ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'b1111; id_valid = 1; id_kind = 3'd1;
    tick();
    check_state("set_1111", 1'b1, 1'b1, 4'b1111);
    stall = 1; reset = 1; flush = 1;
    tick();
    check_state("reset_in_stall", 1'b0, 1'b0, 4'b0000);
    idle_inputs();
    id_valid = 1; id_kind = 3'd2; id_cond = 4'd1;
    tick();
    check_state("post_reset_ne", 1'b1, 1'b1, 4'b0000);

    // Full sweep of condition codes against flag values via the bypass path.
    idle_inputs();
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        ex_valid = 1; ex_set_flags = 1; ex_nzcv = 4'(f);
        id_valid = 1; id_kind = 3'd2; id_cond = 4'(c);
        tick();
        check($sformatf("sweep_f%0h_c%0d", f, c), {br_valid, br_taken}, {1'b1, cond_ref(4'(f), 4'(c))});
      end
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      ex_valid     = $urandom_range(0, 1);
      ex_set_flags = $urandom_range(0, 1);
      ex_nzcv      = 4'($urandom);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_kind      = 3'($urandom_range(0, 7));
      id_cond      = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       id_operand = 64'h0;
        1:       id_operand = 64'h1 << $urandom_range(0, 63);
        default: id_operand = {$urandom, $urandom};
      endcase
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      tick();
      check($sformatf("rand_%0d", i), {br_valid, br_taken, flags_q}, {m_valid, m_taken, m_flags});
      check($sformatf("rand_inv_%0d", i), br_taken & ~br_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
